// File: rtl/apb_gpio.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio
// Brief    : APB3 GPIO with input sync, prescaled debounce, edge capture, irq
// Revision : 1.0
// ============================================================================
module apb_gpio #(
  parameter int               N_IN          = 3,
  parameter int               N_OUT         = 3,
  parameter logic [N_IN-1:0]  IN_INVERT     = 3'b110,
  parameter logic [N_OUT-1:0] OUT_INVERT    = 3'b011,
  parameter int               DEBOUNCE_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [1:0]       apb_addr,
  input  logic             apb_enable,
  input  logic             apb_write,
  input  logic [31:0]      apb_wdata,
  output logic [31:0]      apb_rdata,
  input  logic [N_IN-1:0]  pins_in,
  output logic [N_OUT-1:0] pins_out,
  output logic             irq
);

  localparam logic [1:0] c_ADDR_IN     = 2'd0;
  localparam logic [1:0] c_ADDR_OUT    = 2'd1;
  localparam logic [1:0] c_ADDR_EDGE   = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS = 2'd3;

  logic [DEBOUNCE_BITS-1:0] r_presc;
  logic [N_IN-1:0]          r_sync1;
  logic [N_IN-1:0]          r_sync2;
  logic [N_IN-1:0]          r_sample;
  logic [N_IN-1:0]          r_deb;
  logic [N_OUT-1:0]         r_out;
  logic [N_IN-1:0]          r_rise_en;
  logic [N_IN-1:0]          r_fall_en;
  logic [N_IN-1:0]          r_stat_rise;
  logic [N_IN-1:0]          r_stat_fall;
  logic [31:0]              r_rdata;
  logic                     r_irq;

  logic                     w_tick;
  logic [N_IN-1:0]          w_same;
  logic [N_IN-1:0]          w_deb_next;
  logic [N_IN-1:0]          w_rise_ev;
  logic [N_IN-1:0]          w_fall_ev;
  logic                     w_wr;
  logic [N_IN-1:0]          w_clr_rise;
  logic [N_IN-1:0]          w_clr_fall;
  logic [31:0]              w_rd_word;
  logic                     w_unused;

  assign w_tick = &r_presc;

  // A bit is accepted only when two consecutive ticks see the same level.
  assign w_same     = ~(r_sync2 ^ r_sample);
  assign w_deb_next = w_tick ? ((r_deb & ~w_same) | (r_sync2 & w_same)) : r_deb;
  assign w_rise_ev  =  w_deb_next & ~r_deb & r_rise_en;
  assign w_fall_ev  = ~w_deb_next &  r_deb & r_fall_en;

  assign w_wr       = sel & apb_enable & apb_write;
  assign w_clr_rise = (w_wr && apb_addr == c_ADDR_STATUS) ? apb_wdata[N_IN-1:0]   : '0;
  assign w_clr_fall = (w_wr && apb_addr == c_ADDR_STATUS) ? apb_wdata[16 +: N_IN] : '0;

  always_comb begin
    w_rd_word = '0;
    case (apb_addr)
      c_ADDR_IN:   w_rd_word[N_IN-1:0]  = r_deb;
      c_ADDR_OUT:  w_rd_word[N_OUT-1:0] = r_out;
      c_ADDR_EDGE: begin
        w_rd_word[N_IN-1:0]   = r_rise_en;
        w_rd_word[16 +: N_IN] = r_fall_en;
      end
      default: begin
        w_rd_word[N_IN-1:0]   = r_stat_rise;
        w_rd_word[16 +: N_IN] = r_stat_fall;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc     <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sample    <= '0;
      r_deb       <= '0;
      r_out       <= '0;
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_stat_rise <= '0;
      r_stat_fall <= '0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_sync1 <= pins_in ^ IN_INVERT;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_sample <= r_sync2;
      end
      r_deb <= w_deb_next;

      // Set wins over a simultaneous write-one-to-clear.
      r_stat_rise <= (r_stat_rise & ~w_clr_rise) | w_rise_ev;
      r_stat_fall <= (r_stat_fall & ~w_clr_fall) | w_fall_ev;
      r_irq       <= |{r_stat_rise, r_stat_fall};

      if (w_wr && apb_addr == c_ADDR_OUT) begin
        r_out <= apb_wdata[N_OUT-1:0];
      end
      if (w_wr && apb_addr == c_ADDR_EDGE) begin
        r_rise_en <= apb_wdata[N_IN-1:0];
        r_fall_en <= apb_wdata[16 +: N_IN];
      end

      // Read data is captured in the setup phase and held through access.
      if (!sel) begin
        r_rdata <= '0;
      end else if (!apb_enable) begin
        r_rdata <= w_rd_word;
      end
    end
  end

  assign apb_rdata = r_rdata;
  assign irq       = r_irq;
  assign pins_out  = r_out ^ OUT_INVERT;
  assign w_unused  = &{1'b0, apb_wdata};

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio
// Brief    : Randomised + directed bench for apb_gpio against a cycle model
// Revision : 1.0
// ============================================================================
module tb_apb_gpio;

  localparam int          c_D        = 2;
  localparam int          c_PERIOD   = 1 << c_D;
  localparam logic [2:0]  c_IN_INV   = 3'b110;
  localparam logic [2:0]  c_OUT_INV  = 3'b011;
  localparam logic [31:0] c_REG_MASK = 32'h0007_0007;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  apb_addr;
  logic        apb_enable;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic [2:0]  pins_in;
  logic [2:0]  pins_out;
  logic        irq;

  apb_gpio #(
    .N_IN(3), .N_OUT(3), .IN_INVERT(3'b110), .OUT_INVERT(3'b011), .DEBOUNCE_BITS(c_D)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .apb_addr(apb_addr),
    .apb_enable(apb_enable), .apb_write(apb_write), .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata), .pins_in(pins_in), .pins_out(pins_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: registers as plain words, pin history indexed by edge count
  // since reset, a debounce tick every c_PERIOD-th edge.
  logic [2:0]  m_hist [0:8191];
  int          m_edge;
  logic [2:0]  m_last_tick;
  logic [2:0]  m_deb;
  logic [2:0]  m_out;
  logic [31:0] m_en;
  logic [31:0] m_stat;
  logic [31:0] exp_rdata;
  logic        exp_irq;
  logic [2:0]  exp_pins_out;

  function automatic logic [31:0] reg_word(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_deb};
      2'd1:    return {29'd0, m_out};
      2'd2:    return m_en;
      default: return m_stat;
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0]  seen;
    logic [2:0]  new_deb;
    logic [31:0] set_w;
    logic [31:0] clr_w;
    if (reset) begin
      m_edge = 0; m_last_tick = '0; m_deb = '0; m_out = '0; m_en = '0; m_stat = '0;
      exp_rdata = '0; exp_irq = 1'b0; exp_pins_out = c_OUT_INV;
      return;
    end
    exp_irq = (m_stat != 0);
    if (!sel) exp_rdata = '0;
    else if (!apb_enable) exp_rdata = reg_word(apb_addr);
    // The debouncer sees the pin level from two edges ago.
    seen = (m_edge >= 2) ? m_hist[(m_edge - 2) % 8192] : 3'b000;
    m_hist[m_edge % 8192] = pins_in ^ c_IN_INV;
    new_deb = m_deb;
    if (m_edge % c_PERIOD == c_PERIOD - 1) begin
      for (int b = 0; b < 3; b++)
        if (seen[b] == m_last_tick[b]) new_deb[b] = seen[b];
      m_last_tick = seen;
    end
    set_w = '0;
    for (int b = 0; b < 3; b++) begin
      if (!m_deb[b] && new_deb[b] && m_en[b])      set_w[b]      = 1'b1;
      if (m_deb[b] && !new_deb[b] && m_en[16 + b]) set_w[16 + b] = 1'b1;
    end
    clr_w = '0;
    if (sel && apb_enable && apb_write) begin
      case (apb_addr)
        2'd1:    m_out = apb_wdata[2:0];
        2'd2:    m_en  = apb_wdata & c_REG_MASK;
        2'd3:    clr_w = apb_wdata & c_REG_MASK;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr_w) | set_w;
    m_deb  = new_deb;
    m_edge++;
    exp_pins_out = m_out ^ c_OUT_INV;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("rdata", apb_rdata, exp_rdata);
    chk("pins_out", {29'd0, pins_out}, {29'd0, exp_pins_out});
    chk("irq", {31'd0, irq}, {31'd0, exp_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apb_xfer(input logic wr, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    sel = 1'b1; apb_enable = 1'b0; apb_write = wr; apb_addr = a; apb_wdata = d;
    step();
    apb_enable = 1'b1;
    step();
    rd = apb_rdata;
    sel = 1'b0; apb_enable = 1'b0; apb_write = 1'b0;
  endtask

  task automatic do_reset();
    sel = 1'b0; apb_enable = 1'b0; apb_write = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    int          hold;
    reset = 1'b1; sel = 1'b0; apb_addr = '0; apb_enable = 1'b0; apb_write = 1'b0;
    apb_wdata = '0; pins_in = c_IN_INV;
    step();
    do_reset();

    // Reset values
    chk("reset_pins_out", {29'd0, pins_out}, 32'h3);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      apb_xfer(1'b0, a[1:0], 32'h0, rd);
      chk("reset_read", rd, 32'h0);
    end

    // OUT write
    apb_xfer(1'b1, 2'd1, 32'h5, rd);
    chk("out_pins", {29'd0, pins_out}, 32'h6);
    apb_xfer(1'b0, 2'd1, 32'h0, rd);
    chk("out_read", rd, 32'h5);

    // Rise event, latency window, W1C
    apb_xfer(1'b1, 2'd2, 32'h1, rd);
    pins_in = 3'b111;
    n = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (irq) begin n = i; break; end
    end
    chk("rise_irq_latency_ok", {31'd0, (n >= 8 && n <= 11)}, 32'h1);
    apb_xfer(1'b0, 2'd0, 32'h0, rd);
    chk("rise_in", rd, 32'h1);
    apb_xfer(1'b0, 2'd3, 32'h0, rd);
    chk("rise_status", rd, 32'h1);
    apb_xfer(1'b1, 2'd3, 32'h1, rd);
    step();
    chk("w1c_irq", {31'd0, irq}, 32'h0);
    apb_xfer(1'b0, 2'd3, 32'h0, rd);
    chk("w1c_status", rd, 32'h0);

    // Glitch rejection
    pins_in = 3'b110;
    idle(12);
    apb_xfer(1'b1, 2'd3, c_REG_MASK, rd);
    pins_in = 3'b111;
    idle(3);
    pins_in = 3'b110;
    idle(12);
    apb_xfer(1'b0, 2'd0, 32'h0, rd);
    chk("glitch_in", rd, 32'h0);
    apb_xfer(1'b0, 2'd3, 32'h0, rd);
    chk("glitch_status", rd, 32'h0);

    // Fall-only enables on an inverted pin
    apb_xfer(1'b1, 2'd2, 32'h0001_0000, rd);
    pins_in = 3'b100;
    idle(12);
    apb_xfer(1'b0, 2'd0, 32'h0, rd);
    chk("fall_in_high", rd, 32'h2);
    pins_in = 3'b110;
    idle(12);
    apb_xfer(1'b0, 2'd3, 32'h0, rd);
    chk("fall_bit16_only", rd, 32'h0);
    apb_xfer(1'b1, 2'd2, 32'h0002_0000, rd);
    pins_in = 3'b100;
    idle(12);
    pins_in = 3'b110;
    idle(12);
    apb_xfer(1'b0, 2'd3, 32'h0, rd);
    chk("fall_bit17", rd, 32'h0002_0000);
    apb_xfer(1'b1, 2'd3, c_REG_MASK, rd);

    // Set/clear collision: access edges land on debounce ticks
    apb_xfer(1'b1, 2'd2, 32'h1, rd);
    if (m_edge % 2 != 0) step();
    pins_in = 3'b111;
    for (int i = 0; i < 12; i++) begin
      apb_xfer(1'b1, 2'd3, 32'h1, rd);
      if (m_stat[0]) break;
    end
    apb_xfer(1'b0, 2'd3, 32'h0, rd);
    chk("collision_set_wins", rd, 32'h1);

    // Randomised traffic
    hold = 0;
    for (int it = 0; it < 1500; it++) begin
      if (hold == 0) begin
        pins_in = 3'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 9) < 4) begin
        apb_xfer(1'($urandom), 2'($urandom), $urandom, rd);
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_gpio.md
# apb_gpio

Parametrised APB3 general-purpose I/O controller that replaces the fixed 3-LED / 3-key register in the top level. It provides N_OUT output bits and N_IN input bits with per-bit polarity normalisation, a two-flop synchroniser, shared-prescaler debouncing, and per-input rise/fall event capture with a level interrupt. It sits on the core's APB3 peripheral bus at the GPIO slot. PREADY is tied high, and the top level muxes `apb_rdata` using its registered select.

## Interface
- N_IN, 3: input pin count, 1..16
- N_OUT, 3: output pin count, 1..32
- IN_INVERT, 3'b110: XOR mask applied to raw `pins_in`, N_IN bits
- OUT_INVERT, 3'b011: XOR mask applied to the output register to drive `pins_out`, N_OUT bits
- DEBOUNCE_BITS, 16: prescaler width, ≥1; the sample tick occurs every 2^DEBOUNCE_BITS cycles. Use 2 in simulation.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sel  in  1  APB PSEL for this block, already address-decoded
- apb_addr  in  2  word index, PADDR[3:2]
- apb_enable  in  1  PENABLE
- apb_write  in  1  PWRITE
- apb_wdata  in  32  PWDATA
- apb_rdata  out  32  PRDATA, registered
- pins_in  in  N_IN  raw asynchronous pins
- pins_out  out  N_OUT  output register XOR OUT_INVERT
- irq  out  1  OR of the STATUS register, registered

## Operation
- **Register map** (word index):
  - 0 IN (RO): debounced, normalised inputs, zero-extended.
  - 1 OUT (RW): bits [N_OUT-1:0].
  - 2 EDGE_EN (RW): [N_IN-1:0] enables rise events; [16+N_IN-1:16] enables fall events.
  - 3 STATUS (R/W1C): [N_IN-1:0] rise-seen; [16+N_IN-1:16] fall-seen.
  - Unimplemented bits read 0 and ignore writes.
- **Synchroniser:** sync1 <= pins_in ^ IN_INVERT; sync2 <= sync1.
- **Prescaler:** free-running DEBOUNCE_BITS counter. `tick` = counter all-ones.
- **Debounce**, per bit, on `tick` only:
  - sample <= sync2.
  - If sync2 == sample, then debounced <= sync2.
  - A change must therefore be seen on two consecutive ticks. Any pulse shorter than 2^DEBOUNCE_BITS cycles is rejected.
- **Events:** on the same edge where debounced goes 0→1 (or 1→0), the STATUS rise (or fall) bit is set if the matching EDGE_EN bit is 1. Disabled edges are not recorded.
- **STATUS writes:** a write with a 1 clears the bit; writing 0 has no effect. If a set and a clear hit the same bit on the same edge, the set wins.
- **Clearing enables:** clearing an EDGE_EN bit does not clear an already-set STATUS bit.
- **irq:** irq <= |STATUS, so it lags STATUS by one cycle.

## Timing
- **Reset:** apb_rdata=0, irq=0, and OUT, EDGE_EN, STATUS, sync1, sync2, sample, debounced and the prescaler are all 0.
  - pins_out therefore equals OUT_INVERT during and after reset.
  - Reset mid-debounce discards the pending sample.
  - An input that is high (normalised) at reset release produces a rise after debounce, but it is recorded only if enabled by then.
- **APB setup phase** (sel=1, apb_enable=0): apb_rdata is loaded with the addressed register on that edge and is valid throughout the access phase.
  - When sel=0, apb_rdata <= 0.
- **APB access phase:** a write takes effect on the edge where sel & apb_enable & apb_write.
  - Zero wait states.
  - pins_out changes on that same edge.
- **Read-modify-write race:** a STATUS read during the access phase returns the setup-edge value. An event arriving in the access cycle is not lost, because clear applies only to written-1 bits and set wins.
- **Pin-to-debounced latency:** between 2^D+2 and 2^(D+1)+1 rising edges after the first edge that sees the new level, where D = DEBOUNCE_BITS.
  - STATUS updates on the same edge as debounced.
  - irq follows on the next edge.
- **Prescaler wrap:** all-ones → 0, continuous. It is not affected by APB activity.

## Test plan
Directed scenarios (D=2, defaults otherwise):

- **Reset values:** reset, then read each of words 0-3.
  - Required: all reads return 0, pins_out=3'b011, irq=0.
- **OUT write:** write OUT=0x5.
  - Required: pins_out=3'b110 on the access edge.
  - Read OUT returns 0x00000005.
- **Rise event and W1C:** write EDGE_EN=0x00000001, then drive pins_in[0] 0→1 and hold (normalised 0→1).
  - Required: IN=0x1 and STATUS=0x00000001 within 6-9 edges; irq=1 one edge later.
  - Write STATUS=0x1: STATUS=0 and irq drops on the following edge.
- **Glitch rejection:** pulse pins_in[0] high for 3 cycles.
  - Required: IN stays 0 and STATUS stays 0.
- **Fall event only:** EDGE_EN=0x00010000; pins_in[1] is inverted, so raw 1→0 gives normalised 0→1.
  - Required: no STATUS set.
  - Raw 0→1 afterwards: STATUS=0x00020000 only if bit 17 is enabled; with only bit 16 set, STATUS stays 0.
- **Set/clear collision:** W1C of STATUS bit 0 on the same edge a new enabled rise on bit 0 is debounced.
  - Required: STATUS bit 0 remains 1.
